btn_conditioner: RTL and testbench

Front-end input conditioner for the RNG board. It takes the raw, asynchronous, bouncing push-buttons (catch and load/seed) and synchronises and debounces them. It then produces clean levels plus single-cycle press, release and auto-repeat strobes in the `clk` domain, and sits directly upstream of the LFSR/capture logic. One independent channel is instantiated per button; all channels share the same timing parameters.

---
 rtl/btn_conditioner_if.sv | 28 ++
 rtl/btn_conditioner.sv | 177 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw push-buttons and the conditioned strobe outputs.
// The master side drives the raw buttons and consumes the strobes; the
// conditioner is the slave.
interface btn_conditioner_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM and auto-repeat
// timer per channel. Produces a clean level plus one-cycle press, release and
// repeat strobes, all registered.
module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  btn_conditioner_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W  = $clog2(HMAX + 1);

  // The IDLE/HELD sample that opens a wait already counts as one stable
  // cycle, so the change is accepted when the count held so far is one short.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HC_W-1:0]  HOLD_T  = HC_W'(HOLD_CYCLES);
  localparam logic [HC_W-1:0]  REP_T   = HC_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {IDLE, RISE_WAIT, HELD, FALL_WAIT} state_t;

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] repeat_v;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [HC_W-1:0]  hcnt, hcnt_next, hcnt_inc, hcnt_target;
    logic             first, first_next;
    logic             level_r, level_next;
    logic             press_r, press_next;
    logic             release_r, release_next;
    logic             repeat_r, repeat_next;

    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign hcnt_inc    = hcnt + 1'b1;
    assign hcnt_target = first ? HOLD_T : REP_T;

    // Debounce next-state and strobe decode, then the hold/repeat timer.
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      hcnt_next    = hcnt;
      first_next   = first;
      level_next   = level_r;
      press_next   = 1'b0;
      release_next = 1'b0;
      repeat_next  = 1'b0;

      case (state)
        IDLE: begin
          if (s2[i]) begin
            if (cnt == DB_LAST) begin
              state_next = HELD;
              cnt_next   = '0;
              level_next = 1'b1;
              press_next = 1'b1;
            end else begin
              state_next = RISE_WAIT;
              cnt_next   = cnt_inc;
            end
          end
        end
        RISE_WAIT: begin
          if (!s2[i]) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == DB_LAST) begin
            state_next = HELD;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HELD: begin
          if (!s2[i]) begin
            if (cnt == DB_LAST) begin
              state_next   = IDLE;
              cnt_next     = '0;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              state_next = FALL_WAIT;
              cnt_next   = cnt_inc;
            end
          end
        end
        FALL_WAIT: begin
          if (s2[i]) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt == DB_LAST) begin
            state_next   = IDLE;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase

      // A release wins over a due repeat, so repeat never coincides with it.
      if (press_next || release_next) begin
        hcnt_next  = '0;
        first_next = 1'b1;
      end else if (level_r) begin
        if (hcnt_inc == hcnt_target) begin
          repeat_next = 1'b1;
          hcnt_next   = '0;
          first_next  = 1'b0;
        end else begin
          hcnt_next = hcnt_inc;
        end
      end
    end

    // Channel state, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        hcnt      <= '0;
        first     <= 1'b1;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        hcnt      <= hcnt_next;
        first     <= first_next;
        level_r   <= level_next;
        press_r   <= press_next;
        release_r <= release_next;
        repeat_r  <= repeat_next;
      end
    end

    assign level_v[i]   = level_r;
    assign press_v[i]   = press_r;
    assign release_v[i] = release_r;
    assign repeat_v[i]  = repeat_r;
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_repeat  = repeat_v;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with small timing parameters. Expected strobes are
// queued (edge number, channel, kind) as stimulus is applied and matched
// against every strobe the DUT raises.
module tb_btn_conditioner;
  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 8;

  localparam int K_PRESS   = 1;
  localparam int K_RELEASE = 2;
  localparam int K_REPEAT  = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge cyc equals n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void expect_ev(input int at, input int c, input int kind);
    exp_q.push_back(at * 16 + c * 4 + kind);
  endfunction

  task automatic score(input int c, input int kind);
    int code;
    code = cyc * 16 + c * 4 + kind;
    if (exp_q.size() == 0) chk_val("unexpected_strobe", code, -1);
    else chk_val("strobe", code, exp_q.pop_front());
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (bus.btn_press[c] === 1'b1)   score(c, K_PRESS);
      if (bus.btn_release[c] === 1'b1) score(c, K_RELEASE);
      if (bus.btn_repeat[c] === 1'b1)  score(c, K_REPEAT);
    end
  end

  initial begin
    reset = 1'b1;
    bus.btn_raw = '0;

    wait_to(3);
    chk_val("rst_level",   int'(bus.btn_level),   0);
    chk_val("rst_press",   int'(bus.btn_press),   0);
    chk_val("rst_release", int'(bus.btn_release), 0);
    chk_val("rst_repeat",  int'(bus.btn_repeat),  0);
    reset = 1'b0;

    // Clean press sampled at edge 10, press after 15, repeats +20,+28..+60.
    wait_to(9);
    bus.btn_raw[0] = 1'b1;
    expect_ev(15, 0, K_PRESS);
    for (int j = 0; j < 6; j++) expect_ev(15 + HLD + j * REP, 0, K_REPEAT);
    expect_ev(81, 0, K_RELEASE);
    wait_to(14);
    chk_val("clean_level_early", int'(bus.btn_level), 0);
    wait_to(15);
    chk_val("clean_level", int'(bus.btn_level), 1);
    chk_val("clean_press_vec", int'(bus.btn_press), 1);
    wait_to(16);
    chk_val("clean_press_one_cycle", int'(bus.btn_press), 0);
    wait_to(75);
    bus.btn_raw[0] = 1'b0;
    wait_to(80);
    chk_val("rel_level_before", int'(bus.btn_level), 1);
    wait_to(81);
    chk_val("rel_level_after", int'(bus.btn_level), 0);

    // Bouncy press: 1,0,1,1,0 at edges 115..119, then 1 from 120.
    wait_to(114); bus.btn_raw[0] = 1'b1;
    wait_to(115); bus.btn_raw[0] = 1'b0;
    wait_to(116); bus.btn_raw[0] = 1'b1;
    wait_to(118); bus.btn_raw[0] = 1'b0;
    wait_to(119); bus.btn_raw[0] = 1'b1;
    expect_ev(125, 0, K_PRESS);
    expect_ev(145, 0, K_REPEAT);
    expect_ev(153, 0, K_REPEAT);
    wait_to(124);
    chk_val("bounce_level_early", int'(bus.btn_level), 0);
    wait_to(125);
    chk_val("bounce_level", int'(bus.btn_level), 1);

    // Release glitch of 2 samples (edges 150,151) while held.
    wait_to(149); bus.btn_raw[0] = 1'b0;
    wait_to(151); bus.btn_raw[0] = 1'b1;
    wait_to(153);
    chk_val("glitch_level", int'(bus.btn_level), 1);
    chk_val("glitch_repeat_vec", int'(bus.btn_repeat), 1);
    wait_to(155);
    chk_val("glitch_level_late", int'(bus.btn_level), 1);

    // One-cycle reset at edge 158 with the button still held.
    wait_to(157);
    reset = 1'b1;
    expect_ev(164, 0, K_PRESS);
    expect_ev(184, 0, K_REPEAT);
    expect_ev(192, 0, K_REPEAT);
    expect_ev(200, 0, K_RELEASE);
    wait_to(158);
    reset = 1'b0;
    chk_val("mid_rst_level",   int'(bus.btn_level),   0);
    chk_val("mid_rst_press",   int'(bus.btn_press),   0);
    chk_val("mid_rst_release", int'(bus.btn_release), 0);
    chk_val("mid_rst_repeat",  int'(bus.btn_repeat),  0);
    wait_to(163);
    chk_val("refire_level_early", int'(bus.btn_level), 0);
    wait_to(164);
    chk_val("refire_level", int'(bus.btn_level), 1);

    // Release lands on the edge where a repeat would also be due (200).
    wait_to(194);
    bus.btn_raw[0] = 1'b0;
    wait_to(200);
    chk_val("rel_vs_repeat_level", int'(bus.btn_level), 0);
    chk_val("rel_vs_repeat_repeat", int'(bus.btn_repeat), 0);

    // Both channels together.
    wait_to(219);
    bus.btn_raw = 2'b11;
    expect_ev(225, 0, K_PRESS);
    expect_ev(225, 1, K_PRESS);
    expect_ev(240, 0, K_RELEASE);
    expect_ev(240, 1, K_RELEASE);
    wait_to(225);
    chk_val("both_press_vec", int'(bus.btn_press), 3);
    wait_to(234);
    bus.btn_raw = 2'b00;
    wait_to(240);
    chk_val("both_release_vec", int'(bus.btn_release), 3);

    wait_to(260);
    chk_val("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
